// File: rtl/arm_bundle_decoder.sv
// Recovers the Java bytecode (1 or 2 bytes) behind one packed ARM instruction bundle.
// Bundles that match no known translation are rejected and counted.
module arm_bundle_decoder #(
  parameter int unsigned LANES = 6,
  parameter int unsigned ERR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [32*LANES-1:0] in_instructions,
  input  logic [3:0]         in_quantity,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               out_last,
  output logic               err_pulse,
  output logic [ERR_W-1:0]   err_count
);

  // Match table spans six lanes; narrower bundles are zero-padded up to that.
  localparam int unsigned NL = (LANES > 6) ? LANES : 6;
  localparam int unsigned IW = 32 * NL;

  typedef enum logic [1:0] {IDLE, DECODE, EMIT0, EMIT1} state_t;

  state_t             state_q;
  logic [IW-1:0]      ins_q;
  logic [3:0]         qty_q;
  logic [7:0]         operand_q;
  logic               two_byte_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [7:0]         out_data_q;
  logic               out_last_q;
  logic               err_pulse_q;
  logic [ERR_W-1:0]   err_cnt_q;

  logic [31:0]        lane [6];
  logic [11:0]        imm0, imm1;
  logic               hi_zero, qty_ok;
  logic               match_d, two_byte_d;
  logic [7:0]         opcode_d, operand_d;

  always_comb begin
    for (int unsigned k = 0; k < 6; k++) lane[k] = ins_q[32*k +: 32];
  end

  always_comb begin
    match_d    = 1'b0;
    opcode_d   = '0;
    operand_d  = '0;
    two_byte_d = 1'b0;
    imm0       = lane[0][11:0];
    imm1       = lane[1][11:0];
    hi_zero    = (lane[5] == '0) && (lane[4] == '0);
    qty_ok     = (qty_q >= 4'd2) && (32'(qty_q) <= LANES);
    case (qty_q)
      4'd2: begin
        if (lane[1] == 32'hE92D0002 && lane[0][31:12] == 20'hE3A01) begin
          if (imm0 <= 12'd5) begin
            match_d  = 1'b1;
            opcode_d = 8'h03 + imm0[7:0];
          end
        end else if (lane[1] == 32'hE92D0002 && lane[0][31:12] == 20'hE5913) begin
          if (imm0 <= 12'd3) begin
            match_d  = 1'b1;
            opcode_d = 8'h1A + imm0[7:0];
          end else if (imm0 <= 12'd255) begin
            match_d    = 1'b1;
            opcode_d   = 8'h15;
            operand_d  = imm0[7:0];
            two_byte_d = 1'b1;
          end
        end else if (lane[1][31:12] == 20'hE5813 && lane[0] == 32'hE8BD0001) begin
          if (imm1 <= 12'd3) begin
            match_d  = 1'b1;
            opcode_d = 8'h3B + imm1[7:0];
          end
        end else if (lane[1][31:12] == 20'hE5813 && lane[0] == 32'hE8BD0002) begin
          if (imm1 <= 12'd255) begin
            match_d    = 1'b1;
            opcode_d   = 8'h36;
            operand_d  = imm1[7:0];
            two_byte_d = 1'b1;
          end
        end else if (lane[1] == 32'hE0810002 && lane[0] == 32'hE8BD0006) begin
          match_d  = 1'b1;
          opcode_d = 8'h60;
        end else if (lane[1] == 32'hE92D0003 && lane[0] == 32'hE8BD0003) begin
          match_d  = 1'b1;
          opcode_d = 8'h5F;
        end
      end
      4'd3: begin
        if (lane[2] == 32'hE92D0000 && lane[1] == 32'hE0010002 && lane[0] == 32'hE8BD0006) begin
          match_d  = 1'b1;
          opcode_d = 8'h7E;
        end else if (lane[2] == 32'hE92D0000 && lane[1] == 32'hE0210002 &&
                     lane[0] == 32'hE8BD0006) begin
          match_d  = 1'b1;
          opcode_d = 8'h82;
        end else if (lane[2] == 32'hE92D0002 && lane[1] == 32'hE92D0001 &&
                     lane[0] == 32'hE8BD0001) begin
          match_d  = 1'b1;
          opcode_d = 8'h59;
        end else if (lane[2] == 32'hE92D0003 && lane[1] == 32'hE92D0002 &&
                     lane[0] == 32'hE8BD0003) begin
          match_d  = 1'b1;
          opcode_d = 8'h5A;
        end
      end
      4'd4, 4'd6: begin
        // dup_x2/dup2 also arrive padded to six lanes with the top two cleared
        if (qty_q == 4'd6 && lane[5] == 32'hE92D0004 && lane[4] == 32'hE92D0009 &&
            lane[3] == 32'hE92D0002 && lane[2] == 32'hE92D0004 &&
            lane[1] == 32'hE92D0008 && lane[0] == 32'hE8BD000F) begin
          match_d  = 1'b1;
          opcode_d = 8'h5E;
        end else if ((qty_q == 4'd4 || hi_zero) && lane[3] == 32'hE92D0005 &&
                     lane[2] == 32'hE92D0002 && lane[1] == 32'hE92D0004 &&
                     lane[0] == 32'hE8BD0007) begin
          match_d  = 1'b1;
          opcode_d = 8'h5B;
        end else if ((qty_q == 4'd4 || hi_zero) && lane[3] == 32'hE92D0001 &&
                     lane[2] == 32'hE92D0003 && lane[1] == 32'hE92D0002 &&
                     lane[0] == 32'hE8BD0003) begin
          match_d  = 1'b1;
          opcode_d = 8'h5C;
        end
      end
      4'd5: begin
        if (lane[4] == 32'hE92D0002 && lane[3] == 32'hE92D0005 && lane[2] == 32'hE92D0002 &&
            lane[1] == 32'hE92D0004 && lane[0] == 32'hE8BD0007) begin
          match_d  = 1'b1;
          opcode_d = 8'h5D;
        end
      end
      default: ;
    endcase
    if (!qty_ok) match_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      ins_q       <= '0;
      qty_q       <= '0;
      operand_q   <= '0;
      two_byte_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            ins_q      <= IW'(in_instructions);
            qty_q      <= in_quantity;
            in_ready_q <= 1'b0;
            state_q    <= DECODE;
          end
        end
        DECODE: begin
          operand_q  <= operand_d;
          two_byte_q <= two_byte_d;
          if (match_d) begin
            out_valid_q <= 1'b1;
            out_data_q  <= opcode_d;
            out_last_q  <= !two_byte_d;
            state_q     <= EMIT0;
          end else begin
            err_pulse_q <= 1'b1;
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        EMIT0: begin
          if (out_ready) begin
            if (two_byte_q) begin
              out_data_q <= operand_q;
              out_last_q <= 1'b1;
              state_q    <= EMIT1;
            end else begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
            end
          end
        end
        EMIT1: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;

endmodule

// File: doc/arm_bundle_decoder.md
Name: arm_bundle_decoder

Overview:
- Inverse of the bytecode-to-ARM translator: accepts one packed ARM instruction bundle per transaction (same 192-bit/quantity format the translator hands to the memory writer) and recovers the originating Java bytecode (1 or 2 bytes).
- Sits on the verification and round-trip path, downstream of the translator output. Feeds a byte sink that is compared against the input bytecode ROM image.
- Unrecognised bundles are flagged and counted, never emitted.

Parameters:
- LANES, 6, number of 32-bit lanes in a bundle (instruction width = 32*LANES).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  bundle present
- in_ready  out  1  decoder can accept a bundle
- in_instructions  in  192  packed words; lane k = bits [32k+31:32k]; first-executed word in lane quantity-1, last in lane 0
- in_quantity  in  4  number of meaningful lanes
- out_valid  out  1  bytecode byte present
- out_ready  in  1  sink accepts byte
- out_data  out  8  bytecode byte
- out_last  out  1  final byte of the current bytecode
- err_pulse  out  1  one-cycle flag: bundle rejected
- err_count  out  ERR_W  saturating count of rejected bundles

Behaviour:
- Reset (reset==0 at posedge): state IDLE; in_ready=1; out_valid=0; out_data=0; out_last=0; err_pulse=0; err_count=0. Any in-flight bundle or pending byte is discarded.
- Handshake: a bundle transfers when in_valid && in_ready; a byte transfers when out_valid && out_ready. out_data and out_last hold stable while out_valid && !out_ready.
- States:
  - IDLE: in_ready=1. On transfer, register lanes and quantity, go to DECODE.
  - DECODE: in_ready=0. Match the registered bundle (below) and register opcode, operand and two-byte flag. Match -> EMIT0. No match -> err_pulse=1, err_count+1 (saturating at all-ones), IDLE.
  - EMIT0: out_valid=1, out_data=opcode, out_last=!two_byte. On transfer: go to EMIT1 if two_byte, else IDLE.
  - EMIT1: out_valid=1, out_data=operand, out_last=1. On transfer -> IDLE.
- Latency: bundle accepted at edge t; first byte valid from edge t+2. Throughput is one bundle per 3 cycles (4 for two-byte forms) with no backpressure. No bundle is accepted while emitting.
- Match table, listed first word -> last word (hex). The last word sits in lane 0, and quantity must equal the word count unless noted.
  - iconst_k, k=0..5: E92D0002, E3A01000|k -> 03+k. imm>5 -> reject.
  - iload: E92D0002, E5913000|n. n<=3 -> 1A+n. 4<=n<=255 -> 15, n. n>255 -> reject.
  - istore_n: E5813000|n, E8BD0001. n<=3 -> 3B+n, else reject.
  - istore: E5813000|n, E8BD0002. n<=255 -> 36, n, else reject.
  - iadd: E0810002, E8BD0006 -> 60.
  - iand: E92D0000, E0010002, E8BD0006 (q3) -> 7E.
  - ixor: E92D0000, E0210002, E8BD0006 (q3) -> 82.
  - dup: E92D0002, E92D0001, E8BD0001 (q3) -> 59.
  - dup_x1: E92D0003, E92D0002, E8BD0003 (q3) -> 5A.
  - swap: E92D0003, E8BD0003 -> 5F.
  - dup_x2: E92D0005, E92D0002, E92D0004, E8BD0007 -> 5B.
  - dup2: E92D0001, E92D0003, E92D0002, E8BD0003 -> 5C.
  - dup2_x1: E92D0002, E92D0005, E92D0002, E92D0004, E8BD0007 (q5) -> 5D.
  - dup2_x2: E92D0004, E92D0009, E92D0002, E92D0004, E92D0008, E8BD000F (q6) -> 5E.
  - dup_x2 and dup2: quantity 4 or 6 accepted. With 6, lanes 5:4 must be zero.
- Lanes at or above quantity are ignored, except for the dup_x2/dup2 rule above.
- Quantity 0, 1, or >LANES -> reject.
- Mismatch in any compared bit -> reject.
- err_count never wraps.

Test Plan:
- iconst_3: lanes1:0 = E92D0002, E3A01003, q=2, out_ready=1 -> single byte 06, out_last=1 at t+2, in_ready back to 1 at t+3.
- iload operand: lanes1:0 = E92D0002, E5913007, q=2 -> bytes 15 then 07; out_last=0 then 1. Same with offset 2 -> single byte 1C.
- istore forms: E5813002, E8BD0001 -> 3D. E5813040, E8BD0002 -> 36, 40. E5813105, E8BD0002 -> reject, err_pulse for 1 cycle, err_count=1.
- Backpressure: dup2_x2 bundle, q=6, out_ready held 0 for 5 cycles -> out_valid=1 with out_data=5E stable throughout, in_ready=0. One transfer when out_ready rises.
- Rejects and saturation: q=0, q=7, and a dup bundle with lane 2 = E92D0003 -> 3 rejects. With ERR_W=2, 5 rejects -> err_count sticks at 3.
- Reset mid-emit: istore 36/40 bundle, reset low during EMIT1 -> next cycle out_valid=0, IDLE, err_count=0. A following iadd bundle decodes to 60.
